prog_loader: RTL and testbench

- Sequencer directly upstream of the single-cycle core.
- Load phase: takes a stream of 9-bit instruction words over a valid/ready handshake and writes them into the instruction memory write port at consecutive addresses from 0.
- Run phase: pulses the core's start, waits for its done, and reports the execution cycle count or a timeout.
- Sole driver of the core's start input and the instruction-memory write port.

---
 rtl/prog_loader.sv | 151 +++++++++++++++
 tb/tb_prog_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Instruction loader and run sequencer for the single-cycle core: streams words
// into instruction memory, then starts the core and measures its execution time.
module prog_loader #(
  parameter int unsigned          INSTR_WIDTH = 9,
  parameter int unsigned          ADDR_WIDTH  = 12,
  parameter int unsigned          CYC_WIDTH   = 16,
  parameter logic [CYC_WIDTH-1:0] TIMEOUT     = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_req,
  input  logic [ADDR_WIDTH-1:0]  load_len,
  input  logic                   s_valid,
  input  logic [INSTR_WIDTH-1:0] s_data,
  output logic                   s_ready,
  output logic                   im_wen,
  output logic [ADDR_WIDTH-1:0]  im_waddr,
  output logic [INSTR_WIDTH-1:0] im_wdata,
  output logic                   load_done,
  input  logic                   run_req,
  output logic                   dut_start,
  input  logic                   dut_done,
  output logic                   busy,
  output logic                   run_valid,
  output logic [CYC_WIDTH-1:0]   run_cycles,
  output logic                   run_timeout
);

  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, REPORT} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CYC_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                   im_wen_q, im_wen_d;
  logic [ADDR_WIDTH-1:0]  im_waddr_q, im_waddr_d;
  logic [INSTR_WIDTH-1:0] im_wdata_q, im_wdata_d;
  logic                   load_done_q, load_done_d;
  logic                   dut_start_q, dut_start_d;
  logic                   run_valid_q, run_valid_d;
  logic [CYC_WIDTH-1:0]   run_cycles_q, run_cycles_d;
  logic                   run_timeout_q, run_timeout_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    im_wen_d      = 1'b0;
    im_waddr_d    = im_waddr_q;
    im_wdata_d    = im_wdata_q;
    load_done_d   = 1'b0;
    dut_start_d   = 1'b0;
    run_valid_d   = 1'b0;
    run_cycles_d  = run_cycles_q;
    run_timeout_d = run_timeout_q;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          if (load_len != '0) begin
            len_d   = load_len;
            addr_d  = '0;
            state_d = LOAD;
          end else begin
            load_done_d = 1'b1;
          end
        end else if (run_req) begin
          // Start is raised on entry so it is high for the whole START cycle.
          dut_start_d = 1'b1;
          state_d     = START;
        end
      end
      LOAD: begin
        if (s_valid) begin
          im_wen_d   = 1'b1;
          im_waddr_d = addr_q;
          im_wdata_d = s_data;
          addr_d     = addr_q + 1'b1;
          if (addr_q == len_q - 1'b1) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (dut_done) begin
          run_cycles_d  = cnt_inc;
          run_timeout_d = 1'b0;
          run_valid_d   = 1'b1;
          state_d       = REPORT;
        end else if (cnt_inc == TIMEOUT) begin
          run_cycles_d  = TIMEOUT;
          run_timeout_d = 1'b1;
          run_valid_d   = 1'b1;
          state_d       = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      addr_q        <= '0;
      cnt_q         <= '0;
      im_wen_q      <= 1'b0;
      im_waddr_q    <= '0;
      im_wdata_q    <= '0;
      load_done_q   <= 1'b0;
      dut_start_q   <= 1'b0;
      run_valid_q   <= 1'b0;
      run_cycles_q  <= '0;
      run_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      im_wen_q      <= im_wen_d;
      im_waddr_q    <= im_waddr_d;
      im_wdata_q    <= im_wdata_d;
      load_done_q   <= load_done_d;
      dut_start_q   <= dut_start_d;
      run_valid_q   <= run_valid_d;
      run_cycles_q  <= run_cycles_d;
      run_timeout_q <= run_timeout_d;
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign im_wen      = im_wen_q;
  assign im_waddr    = im_waddr_q;
  assign im_wdata    = im_wdata_q;
  assign load_done   = load_done_q;
  assign dut_start   = dut_start_q;
  assign run_valid   = run_valid_q;
  assign run_cycles  = run_cycles_q;
  assign run_timeout = run_timeout_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected memory writes and run results are
// queued when stimulus is driven and compared when the loader produces them.
module tb_prog_loader;

  localparam int unsigned IW = 9;
  localparam int unsigned AW = 12;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic [AW-1:0] load_len;
  logic          s_valid;
  logic [IW-1:0] s_data;
  logic          s_ready;
  logic          im_wen;
  logic [AW-1:0] im_waddr;
  logic [IW-1:0] im_wdata;
  logic          load_done;
  logic          run_req;
  logic          dut_start;
  logic          dut_done;
  logic          busy;
  logic          run_valid;
  logic [CW-1:0] run_cycles;
  logic          run_timeout;

  prog_loader #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .CYC_WIDTH  (CW),
    .TIMEOUT    (16'd10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_req   (load_req),
    .load_len   (load_len),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .im_wen     (im_wen),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .load_done  (load_done),
    .run_req    (run_req),
    .dut_start  (dut_start),
    .dut_done   (dut_done),
    .busy       (busy),
    .run_valid  (run_valid),
    .run_cycles (run_cycles),
    .run_timeout(run_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int ldone_cnt = 0;

  logic [AW-1:0] wq_addr[$];
  logic [IW-1:0] wq_data[$];
  logic [CW-1:0] rq_cyc[$];
  logic          rq_to[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (im_wen) begin
      wr_cnt++;
      if (wq_addr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else begin
        chk("wr_addr", 32'(im_waddr), 32'(wq_addr.pop_front()));
        chk("wr_data", 32'(im_wdata), 32'(wq_data.pop_front()));
      end
    end
    if (run_valid) begin
      if (rq_cyc.size() == 0) chk("run_unexpected", 32'd1, 32'd0);
      else begin
        chk("run_cycles", 32'(run_cycles), 32'(rq_cyc.pop_front()));
        chk("run_timeout", 32'(run_timeout), 32'(rq_to.pop_front()));
      end
    end
    if (dut_start) start_cnt++;
    if (load_done) ldone_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [IW-1:0] d, input int gap);
    chk("s_ready_load", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = d;
    wq_addr.push_back(a);
    wq_data.push_back(d);
    tick();
    s_valid = 1'b0;
    s_data  = '0;
    repeat (gap) tick();
  endtask

  // done_at = RUN cycle index in which dut_done is raised (0 = never)
  task automatic do_run(input int done_at, input logic stale_done,
                        input logic [CW-1:0] exp_cyc, input logic exp_to, input int exp_lat);
    int n;
    rq_cyc.push_back(exp_cyc);
    rq_to.push_back(exp_to);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("start_high", 32'(dut_start), 32'd1);
    dut_done = stale_done;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      n = i;
      if (i == 1) chk("start_low", 32'(dut_start), 32'd0);
      if (run_valid) break;
      dut_done = (i == done_at);
    end
    dut_done = 1'b0;
    chk("run_latency", 32'(n), 32'(exp_lat));
    tick();
    chk("run_valid_drop", 32'(run_valid), 32'd0);
    chk("cycles_hold", 32'(run_cycles), 32'(exp_cyc));
    chk("timeout_hold", 32'(run_timeout), 32'(exp_to));
    chk("busy_after_run", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; load_req = 1'b0; load_len = '0; s_valid = 1'b0;
    s_data = '0; run_req = 1'b0; dut_done = 1'b0;
    repeat (2) tick();
    chk("rst_im_wen", 32'(im_wen), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_run_cycles", 32'(run_cycles), 32'd0);
    chk("rst_run_timeout", 32'(run_timeout), 32'd0);
    chk("rst_outs", {28'd0, run_valid, load_done, dut_start, im_wen}, 32'd0);
    reset = 1'b1;
    tick();

    // Reset in the middle of a load
    load_req = 1'b1; load_len = 12'd8;
    tick();
    load_req = 1'b0;
    send_word(12'd0, 9'h011, 0);
    send_word(12'd1, 9'h022, 0);
    send_word(12'd2, 9'h033, 0);
    chk("mid_im_wen", 32'(im_wen), 32'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("async_im_wen", 32'(im_wen), 32'd0);
    chk("async_s_ready", 32'(s_ready), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_no_done", 32'(load_done), 32'd0);
    #1 reset = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wq", 32'(wq_addr.size()), 32'd0);

    // Four-word load with valid gaps; restarts at address 0
    wr_cnt = 0;
    ldone_cnt = 0;
    load_req = 1'b1; load_len = 12'd4;
    tick();
    load_req = 1'b0;
    chk("load_busy", 32'(busy), 32'd1);
    send_word(12'd0, 9'h1A0, 1);
    send_word(12'd1, 9'h041, 2);
    send_word(12'd2, 9'h1FF, 0);
    send_word(12'd3, 9'h000, 0);
    chk("last_wen", 32'(im_wen), 32'd1);
    chk("last_addr", 32'(im_waddr), 32'd3);
    chk("load_done_last", 32'(load_done), 32'd1);
    chk("s_ready_after", 32'(s_ready), 32'd0);
    tick();
    chk("load_done_once", 32'(load_done), 32'd0);
    chk("wr_count4", 32'(wr_cnt), 32'd4);
    chk("ldone_count", 32'(ldone_cnt), 32'd1);

    // Zero-length load
    load_req = 1'b1; load_len = 12'd0;
    tick();
    load_req = 1'b0;
    chk("zlen_done", 32'(load_done), 32'd1);
    chk("zlen_busy", 32'(busy), 32'd0);
    chk("zlen_wen", 32'(im_wen), 32'd0);
    tick();
    chk("zlen_done_drop", 32'(load_done), 32'd0);
    chk("zlen_wr_count", 32'(wr_cnt), 32'd4);

    // Runs: normal, done exactly at timeout, timeout with stale done in START
    start_cnt = 0;
    do_run(5, 1'b0, 16'd5, 1'b0, 6);
    chk("start_pulses1", 32'(start_cnt), 32'd1);
    do_run(10, 1'b0, 16'd10, 1'b0, 11);
    do_run(0, 1'b1, 16'd10, 1'b1, 11);
    do_run(3, 1'b1, 16'd3, 1'b0, 4);
    chk("start_pulses4", 32'(start_cnt), 32'd4);

    // load_req and run_req together: load wins, run_req while busy ignored
    load_req = 1'b1; run_req = 1'b1; load_len = 12'd2;
    tick();
    load_req = 1'b0;
    chk("both_s_ready", 32'(s_ready), 32'd1);
    chk("both_no_start", 32'(dut_start), 32'd0);
    tick();
    run_req = 1'b0;
    send_word(12'd0, 9'h155, 0);
    send_word(12'd1, 9'h0AA, 0);
    repeat (4) tick();
    chk("both_start_cnt", 32'(start_cnt), 32'd4);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_wr_count", 32'(wr_cnt), 32'd6);
    chk("wq_empty", 32'(wq_addr.size()), 32'd0);
    chk("rq_empty", 32'(rq_cyc.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
